// File: rtl/c3_heap_pq_unit.sv
// c3_heap_pq_unit
// Binary-heap priority queue that executes the C3 PUSH/POP/REPLACE/PEEK
// instructions. It sits in the execute stage beside the SIMD datapath. One
// instruction is in flight at a time. The result is returned as a one-cycle
// pulse tagged with the destination register.
//
// Parameters:
//   KEY_W    key/data width in bits
//   DEPTH    heap capacity (power of two, >= 2)
//   MAX_HEAP 0 = min-heap (smallest at root), 1 = max-heap
//   RD_W     destination-register tag width
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   in_v / in_ready  issue handshake; in_ready is high only while idle
//   in_op            00 PUSH, 01 POP, 10 REPLACE, 11 PEEK
//   rd, in_data      destination tag and key operand
//   out_v            one-cycle result pulse
//   out_rd           tag of the completed instruction
//   out_data         result value
//   out_err          instruction rejected (full on PUSH, empty otherwise)
//   count            current occupancy
module c3_heap_pq_unit #(
    parameter int KEY_W    = 32,
    parameter int DEPTH    = 16,
    parameter int MAX_HEAP = 0,
    parameter int RD_W     = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_v,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [RD_W-1:0]        rd,
    input  logic [KEY_W-1:0]       in_data,
    output logic                   out_v,
    output logic [RD_W-1:0]        out_rd,
    output logic [KEY_W-1:0]       out_data,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = AW + 2;

    localparam logic [1:0] OP_PUSH    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_REPLACE = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SIFT_UP   = 2'd1,
        SIFT_DOWN = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t           state_r;
    logic [1:0]       op_r;
    logic [RD_W-1:0]  rd_r;
    logic             err_r;
    logic [KEY_W-1:0] result_r;
    logic [AW-1:0]    idx_r;
    logic [CW-1:0]    count_r;
    logic [KEY_W-1:0] heap_r [DEPTH];

    logic             out_v_r;
    logic [RD_W-1:0]  out_rd_r;
    logic [KEY_W-1:0] out_data_r;
    logic             out_err_r;

    logic             full_s;
    logic             empty_s;
    logic [AW-1:0]    last_s;
    logic [AW-1:0]    parent_s;
    logic             up_swap_s;
    logic [XW-1:0]    count_x_s;
    logic [XW-1:0]    left_s;
    logic [XW-1:0]    right_s;
    logic             left_ok_s;
    logic             right_ok_s;
    logic             pick_right_s;
    logic [AW-1:0]    child_s;
    logic             down_swap_s;
    logic             child_leaf_s;

    // Strict ordering: equal keys never count as better, so they never swap.
    function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        if (MAX_HEAP != 0) begin
            return a > b;
        end else begin
            return a < b;
        end
    endfunction

    assign in_ready = (state_r == IDLE);
    assign out_v    = out_v_r;
    assign out_rd   = out_rd_r;
    assign out_data = out_data_r;
    assign out_err  = out_err_r;
    assign count    = count_r;

    // Occupancy flags plus the single compare each sift cycle needs.
    always_comb begin
        full_s       = (count_r == CW'(DEPTH));
        empty_s      = (count_r == {CW{1'b0}});
        last_s       = AW'(count_r - CW'(1'b1));
        parent_s     = (idx_r - AW'(1'b1)) >> 1;
        up_swap_s    = (idx_r != {AW{1'b0}}) && better(heap_r[idx_r], heap_r[parent_s]);
        count_x_s    = {1'b0, count_r};
        // Child indices get two extra bits so they never wrap near the end of the array.
        left_s       = {1'b0, idx_r, 1'b1};
        right_s      = left_s + XW'(1'b1);
        left_ok_s    = (left_s < count_x_s);
        right_ok_s   = (right_s < count_x_s);
        // Ties between the two children go to the left child.
        pick_right_s = right_ok_s && better(heap_r[right_s[AW-1:0]], heap_r[left_s[AW-1:0]]);
        child_s      = pick_right_s ? right_s[AW-1:0] : left_s[AW-1:0];
        down_swap_s  = left_ok_s && better(heap_r[child_s], heap_r[idx_r]);
        // A node with no children needs no further compare, so the sift ends at once.
        child_leaf_s = ({1'b0, child_s, 1'b1} >= count_x_s);
    end

    // Control FSM: latch the instruction at issue, walk the sift, then emit the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            op_r       <= OP_PUSH;
            rd_r       <= {RD_W{1'b0}};
            err_r      <= 1'b0;
            result_r   <= {KEY_W{1'b0}};
            idx_r      <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            out_v_r    <= 1'b0;
            out_rd_r   <= {RD_W{1'b0}};
            out_data_r <= {KEY_W{1'b0}};
            out_err_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_v) begin
                        op_r     <= in_op;
                        rd_r     <= rd;
                        err_r    <= 1'b0;
                        idx_r    <= {AW{1'b0}};
                        result_r <= heap_r[0];
                        case (in_op)
                            OP_PUSH: begin
                                if (full_s) begin
                                    err_r   <= 1'b1;
                                    state_r <= RESP;
                                end else begin
                                    idx_r   <= count_r[AW-1:0];
                                    count_r <= count_r + CW'(1'b1);
                                    state_r <= SIFT_UP;
                                end
                            end
                            OP_POP: begin
                                if (empty_s) begin
                                    err_r   <= 1'b1;
                                    state_r <= RESP;
                                end else begin
                                    count_r <= count_r - CW'(1'b1);
                                    state_r <= SIFT_DOWN;
                                end
                            end
                            OP_REPLACE: begin
                                if (empty_s) begin
                                    err_r   <= 1'b1;
                                    state_r <= RESP;
                                end else begin
                                    state_r <= SIFT_DOWN;
                                end
                            end
                            default: begin
                                err_r   <= empty_s;
                                state_r <= RESP;
                            end
                        endcase
                    end
                end
                SIFT_UP: begin
                    if (up_swap_s) begin
                        idx_r   <= parent_s;
                        state_r <= (parent_s == {AW{1'b0}}) ? RESP : SIFT_UP;
                    end else begin
                        state_r <= RESP;
                    end
                end
                SIFT_DOWN: begin
                    if (down_swap_s) begin
                        idx_r   <= child_s;
                        state_r <= child_leaf_s ? RESP : SIFT_DOWN;
                    end else begin
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    // First RESP cycle raises out_v; the second drops it and returns to idle,
                    // so in_ready rises only after the pulse.
                    if (!out_v_r) begin
                        out_v_r    <= 1'b1;
                        out_rd_r   <= rd_r;
                        out_err_r  <= err_r;
                        out_data_r <= err_r ? {KEY_W{1'b0}} :
                                      ((op_r == OP_PUSH) ? heap_r[0] : result_r);
                    end else begin
                        out_v_r <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Heap storage: insert or root update at issue, then at most one swap per sift cycle.
    always_ff @(posedge clk) begin
        case (state_r)
            IDLE: begin
                if (in_v) begin
                    case (in_op)
                        OP_PUSH: begin
                            if (!full_s) begin
                                heap_r[count_r[AW-1:0]] <= in_data;
                            end
                        end
                        OP_POP: begin
                            if (!empty_s) begin
                                heap_r[0] <= heap_r[last_s];
                            end
                        end
                        OP_REPLACE: begin
                            if (!empty_s) begin
                                heap_r[0] <= in_data;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            SIFT_UP: begin
                if (up_swap_s) begin
                    heap_r[idx_r]    <= heap_r[parent_s];
                    heap_r[parent_s] <= heap_r[idx_r];
                end
            end
            SIFT_DOWN: begin
                if (down_swap_s) begin
                    heap_r[idx_r]   <= heap_r[child_s];
                    heap_r[child_s] <= heap_r[idx_r];
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_c3_heap_pq_unit.sv
module tb_c3_heap_pq_unit;
    localparam int DP = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        mn_in_v, mn_ready, mn_out_v, mn_err;
    logic [1:0]  mn_op;
    logic [4:0]  mn_rd, mn_out_rd, mn_count;
    logic [31:0] mn_in_data, mn_out_data;
    logic        mx_in_v, mx_ready, mx_out_v, mx_err;
    logic [1:0]  mx_op;
    logic [4:0]  mx_rd, mx_out_rd, mx_count;
    logic [31:0] mx_in_data, mx_out_data;

    c3_heap_pq_unit #(.KEY_W(32), .DEPTH(DP), .MAX_HEAP(0), .RD_W(5)) dut_min (
        .clk(clk), .reset(rst), .in_v(mn_in_v), .in_ready(mn_ready), .in_op(mn_op),
        .rd(mn_rd), .in_data(mn_in_data), .out_v(mn_out_v), .out_rd(mn_out_rd),
        .out_data(mn_out_data), .out_err(mn_err), .count(mn_count));

    c3_heap_pq_unit #(.KEY_W(32), .DEPTH(DP), .MAX_HEAP(1), .RD_W(5)) dut_max (
        .clk(clk), .reset(rst), .in_v(mx_in_v), .in_ready(mx_ready), .in_op(mx_op),
        .rd(mx_rd), .in_data(mx_in_data), .out_v(mx_out_v), .out_rd(mx_out_rd),
        .out_data(mx_out_data), .out_err(mx_err), .count(mx_count));

    bit          sel;
    logic        s_v, s_ready, s_err;
    logic [4:0]  s_rd, s_count;
    logic [31:0] s_data;
    assign s_v     = sel ? mx_out_v    : mn_out_v;
    assign s_ready = sel ? mx_ready    : mn_ready;
    assign s_err   = sel ? mx_err      : mn_err;
    assign s_rd    = sel ? mx_out_rd   : mn_out_rd;
    assign s_count = sel ? mx_count    : mn_count;
    assign s_data  = sel ? mx_out_data : mn_out_data;

    int checks = 0;
    int failures = 0;

    // Reference contents as plain unordered multisets.
    int unsigned q_mn[$];
    int unsigned q_mx[$];

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          e_err;
        logic [31:0] e_data;
        int          e_cnt;
        int          e_lat;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int best_of(input int unsigned q[$], input bit mx);
        int b = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (mx ? (q[i] > q[b]) : (q[i] < q[b])) b = i;
        end
        return b;
    endfunction

    task automatic model(input bit which, input logic [1:0] op, input logic [31:0] d,
                         output bit e_err, output logic [31:0] e_data, output bit dchk,
                         output int e_cnt);
        int unsigned q[$];
        int bi;
        q = which ? q_mx : q_mn;
        e_err = 1'b0; e_data = 32'd0; dchk = 1'b1;
        case (op)
            2'b00: begin
                if (q.size() == DP) begin e_err = 1'b1; dchk = 1'b0; end
                else begin q.push_back(d); e_data = q[best_of(q, which)]; end
            end
            2'b01: begin
                if (q.size() == 0) e_err = 1'b1;
                else begin bi = best_of(q, which); e_data = q[bi]; q.delete(bi); end
            end
            2'b10: begin
                if (q.size() == 0) e_err = 1'b1;
                else begin bi = best_of(q, which); e_data = q[bi]; q.delete(bi); q.push_back(d); end
            end
            default: begin
                if (q.size() == 0) e_err = 1'b1;
                else e_data = q[best_of(q, which)];
            end
        endcase
        e_cnt = q.size();
        if (which) q_mx = q; else q_mn = q;
    endtask

    task automatic drive(input bit which, input logic v, input logic [1:0] op,
                         input logic [4:0] r, input logic [31:0] d);
        if (which) begin mx_in_v = v; mx_op = op; mx_rd = r; mx_in_data = d; end
        else       begin mn_in_v = v; mn_op = op; mn_rd = r; mn_in_data = d; end
    endtask

    // Issue one instruction at a falling edge; keep in_v high with a junk PUSH while busy.
    task automatic do_op(input bit which, input logic [1:0] op, input logic [4:0] r,
                         input logic [31:0] d, output logic err, output logic [31:0] data,
                         output logic [4:0] ord, output logic [4:0] cnt, output int lat);
        int w = 0;
        sel = which;
        #0;
        while (!s_ready && w < 30) begin @(negedge clk); w++; end
        if (!s_ready) chk("ready_timeout", 0, 1);
        drive(which, 1'b1, op, r, d);
        @(posedge clk);
        #1 drive(which, 1'b1, 2'b00, 5'd31, 32'd0);
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (s_v) begin lat = c; break; end
        end
        drive(which, 1'b0, 2'b00, 5'd0, 32'd0);
        err = s_err; data = s_data; ord = s_rd; cnt = s_count;
        if (lat == 0) begin
            chk("resp_timeout", 0, 1);
        end else begin
            chk("ready_low_during_resp", s_ready, 0);
            @(negedge clk);
            chk("out_v_single_pulse", s_v, 0);
            chk("ready_after_resp", s_ready, 1);
        end
    endtask

    task automatic apply(input bit which, input vec_t v, input string name);
        bit m_err, dchk; logic [31:0] m_data; int m_cnt;
        logic err; logic [31:0] data; logic [4:0] ord, cnt; int lat;
        bit ok;
        model(which, v.op, v.data, m_err, m_data, dchk, m_cnt);
        do_op(which, v.op, v.rd, v.data, err, data, ord, cnt, lat);
        chk({name, "_err"}, err, v.e_err);
        if (!(v.e_err && v.op == 2'b00)) chk({name, "_data"}, data, v.e_data);
        chk({name, "_rd"}, ord, v.rd);
        chk({name, "_count"}, cnt, v.e_cnt);
        if (v.e_lat > 0) begin
            chk({name, "_lat"}, lat, v.e_lat);
        end else begin
            ok = (v.e_err || v.op == 2'b11) ? (lat == 2) : (lat >= 3 && lat <= 6);
            chk({name, "_lat_range"}, ok, 1);
        end
    endtask

    // Expectations come from the reference model (used for sequences and random traffic).
    task automatic run_model(input bit which, input logic [1:0] op, input logic [4:0] r,
                             input logic [31:0] d, input string name);
        vec_t v;
        bit e_err, dchk; logic [31:0] e_data; int e_cnt;
        int unsigned save_q[$];
        save_q = which ? q_mx : q_mn;
        model(which, op, d, e_err, e_data, dchk, e_cnt);
        if (which) q_mx = save_q; else q_mn = save_q;
        v = '{op: op, rd: r, data: d, e_err: e_err, e_data: e_data, e_cnt: e_cnt, e_lat: 0};
        apply(which, v, name);
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{2'b11, 5'd3,  32'd0, 1'b1, 32'd0, 0, 2};
        tbl[1]  = '{2'b00, 5'd1,  32'd5, 1'b0, 32'd5, 1, 0};
        tbl[2]  = '{2'b00, 5'd2,  32'd3, 1'b0, 32'd3, 2, 0};
        tbl[3]  = '{2'b00, 5'd4,  32'd8, 1'b0, 32'd3, 3, 0};
        tbl[4]  = '{2'b00, 5'd5,  32'd1, 1'b0, 32'd1, 4, 4};
        tbl[5]  = '{2'b11, 5'd6,  32'd0, 1'b0, 32'd1, 4, 2};
        tbl[6]  = '{2'b10, 5'd7,  32'd7, 1'b0, 32'd1, 4, 0};
        tbl[7]  = '{2'b01, 5'd8,  32'd0, 1'b0, 32'd3, 3, 0};
        tbl[8]  = '{2'b01, 5'd9,  32'd0, 1'b0, 32'd5, 2, 0};
        tbl[9]  = '{2'b01, 5'd10, 32'd0, 1'b0, 32'd7, 1, 0};
        tbl[10] = '{2'b01, 5'd11, 32'd0, 1'b0, 32'd8, 0, 0};
        tbl[11] = '{2'b01, 5'd12, 32'd0, 1'b1, 32'd0, 0, 2};
        tbl[12] = '{2'b10, 5'd13, 32'd9, 1'b1, 32'd0, 0, 2};

        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
        drive(1'b1, 1'b0, 2'b00, 5'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("reset_out_v", mn_out_v, 0);
        chk("reset_out_rd", mn_out_rd, 0);
        chk("reset_out_data", mn_out_data, 0);
        chk("reset_out_err", mn_err, 0);
        chk("reset_count", mn_count, 0);
        chk("reset_in_ready", mn_ready, 1);
        chk("reset_max_count", mx_count, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) apply(1'b0, tbl[i], $sformatf("vec%0d", i));

        // Fill with descending keys: every push becomes the new root.
        for (int k = 16; k >= 1; k--) begin
            vec_t v;
            v = '{2'b00, 5'(k), 32'(k), 1'b0, 32'(k), 17 - k, 0};
            apply(1'b0, v, $sformatf("fill%0d", k));
        end
        apply(1'b0, '{2'b00, 5'd20, 32'd0, 1'b1, 32'd0, 16, 2}, "push_full");
        apply(1'b0, '{2'b11, 5'd21, 32'd0, 1'b0, 32'd1, 16, 2}, "peek_full");
        for (int k = 1; k <= 16; k++) begin
            vec_t v;
            v = '{2'b01, 5'(k), 32'd0, 1'b0, 32'(k), 16 - k, 0};
            apply(1'b0, v, $sformatf("drain%0d", k));
        end
        apply(1'b0, '{2'b01, 5'd22, 32'd0, 1'b1, 32'd0, 0, 2}, "pop_empty");

        // Max-heap ordering with duplicate keys.
        apply(1'b1, '{2'b00, 5'd1, 32'd5, 1'b0, 32'd5, 1, 0}, "mx_push5");
        apply(1'b1, '{2'b00, 5'd2, 32'd3, 1'b0, 32'd5, 2, 0}, "mx_push3");
        apply(1'b1, '{2'b00, 5'd3, 32'd8, 1'b0, 32'd8, 3, 0}, "mx_push8");
        apply(1'b1, '{2'b00, 5'd4, 32'd4, 1'b0, 32'd8, 4, 0}, "mx_push4a");
        apply(1'b1, '{2'b00, 5'd5, 32'd4, 1'b0, 32'd8, 5, 0}, "mx_push4b");
        apply(1'b1, '{2'b01, 5'd6, 32'd0, 1'b0, 32'd8, 4, 0}, "mx_pop8");
        apply(1'b1, '{2'b01, 5'd7, 32'd0, 1'b0, 32'd5, 3, 0}, "mx_pop5");
        apply(1'b1, '{2'b01, 5'd8, 32'd0, 1'b0, 32'd4, 2, 0}, "mx_pop4a");
        apply(1'b1, '{2'b01, 5'd9, 32'd0, 1'b0, 32'd4, 1, 0}, "mx_pop4b");
        apply(1'b1, '{2'b01, 5'd10, 32'd0, 1'b0, 32'd3, 0, 0}, "mx_pop3");

        // Random traffic against the multiset model, both polarities.
        for (int n = 0; n < 600; n++) begin
            bit w;
            logic [1:0] op;
            logic [31:0] d;
            w  = (n >= 400);
            op = 2'($urandom_range(0, 3));
            d  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
            run_model(w, op, 5'($urandom_range(0, 31)), d, $sformatf("rnd%0d", n));
        end

        // Reset while the max instance is mid SIFT_DOWN.
        while (q_mx.size() < 4) run_model(1'b1, 2'b00, 5'd1, 32'($urandom_range(0, 99)), "pre_rst_push");
        sel = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b01, 5'd9, 32'd0);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 2'b00, 5'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midsift_rst_count", mx_count, 0);
        chk("midsift_rst_out_v", mx_out_v, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("midsift_ready", mx_ready, 1);
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (mx_out_v) seen++;
            end
            chk("midsift_no_resp", seen, 0);
        end
        q_mx.delete();
        q_mn.delete();
        apply(1'b1, '{2'b11, 5'd17, 32'd0, 1'b1, 32'd0, 0, 2}, "post_rst_peek");
        apply(1'b1, '{2'b00, 5'd18, 32'd42, 1'b0, 32'd42, 1, 0}, "post_rst_push");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
